// File: rtl/conv_round_if.sv
// conv_round_if: sample bus for the convergent rounding word-width reducer.
//   i_ce   : clock enable. The reducer's output register loads only while this is high.
//   i_val  : signed input sample, IWID bits, two's complement.
//   o_val  : signed, registered, rounded output sample, OWID bits.
// Modports:
//   master : the producer. Drives i_ce and i_val, and observes o_val.
//   slave  : the reducer. Consumes i_ce and i_val, and drives o_val.
interface conv_round_if #(
    parameter int IWID = 16,
    parameter int OWID = 8
);
    logic                   i_ce;
    logic signed [IWID-1:0] i_val;
    logic signed [OWID-1:0] o_val;

    modport master (
        output i_ce,
        output i_val,
        input  o_val
    );

    modport slave (
        input  i_ce,
        input  i_val,
        output o_val
    );
endinterface

// File: rtl/conv_round.sv
// conv_round: registered convergent (round-half-to-even) word-width reducer.
// The block maps an IWID-bit signed sample to OWID bits in three steps:
//   1. It discards the SHIFT MSBs. This scales by 2^SHIFT with no overflow check.
//   2. It drops enough LSBs to reach OWID bits, rounding ties to the even result.
//   3. It registers the result, so the latency is one enabled cycle.
// Any increment that rounding adds wraps modulo 2^OWID. There is no saturation.
// Ports:
//   i_clk   : clock. All state changes on the rising edge.
//   i_reset : synchronous, active-high reset. It clears o_val and takes priority over i_ce.
//   bus     : slave side of conv_round_if, carrying i_ce, i_val and o_val.
module conv_round #(
    parameter int IWID  = 16,
    parameter int OWID  = 8,
    parameter int SHIFT = 0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    conv_round_if.slave  bus
);
    // K is the number of significant bits still retained after the MSB discard.
    localparam int K = IWID - SHIFT;
    localparam int D = K - OWID;

    logic signed [OWID-1:0] next_val;
    logic signed [OWID-1:0] val_p0;

    if (K <= 0 || OWID < 1) begin : g_illegal
        $error("conv_round: illegal configuration IWID=%0d OWID=%0d SHIFT=%0d", IWID, OWID, SHIFT);
        assign next_val = '0;
    end else if (IWID == OWID) begin : g_pass
        assign next_val = bus.i_val;
    end else if (K < OWID) begin : g_extend
        // Fewer retained bits than the output holds: sign-extend from bit K-1.
        assign next_val = {{(OWID-K){bus.i_val[K-1]}}, bus.i_val[K-1:0]};
    end else if (K == OWID) begin : g_exact
        assign next_val = bus.i_val[K-1:0];
    end else begin : g_round
        // The mask covers the dropped bits below the half bit. When exactly one
        // bit is dropped (D == 1) the mask is zero, so nothing counts as "rest"
        // and the rule reduces to trunc + (lost & lsb).
        localparam logic [K-1:0] REST_MASK = K'((64'(1) << (D-1)) - 64'(1));

        function automatic logic [OWID-1:0] round_half_even(input logic [K-1:0] x);
            logic [OWID-1:0] trunc;
            logic            half;
            logic            rest;
            logic            lsb;
            trunc = x[K-1:D];
            half  = x[D-1];
            rest  = |(x & REST_MASK);
            lsb   = x[D];
            // Round up above half. At exactly half, round up only when the
            // truncated value is odd, which lands on the even neighbour.
            return trunc + OWID'(half & (rest | lsb));
        endfunction

        assign next_val = round_half_even(bus.i_val[K-1:0]);
    end

    // Stage p0: output register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            val_p0 <= '0;
        end else if (bus.i_ce) begin
            val_p0 <= next_val;
        end
    end

    assign bus.o_val = val_p0;
endmodule

// File: tb/tb_conv_round.sv
module tb_conv_round;
    localparam int N = 6;
    // Configurations under test. Each entry is {IWID, OWID, SHIFT}.
    localparam int IW [N] = '{8, 17, 8, 5, 8, 12};
    localparam int OW [N] = '{4, 17, 6, 4, 6, 5};
    localparam int SH [N] = '{0, 0, 2, 0, 4, 3};

    logic        clk;
    logic        rst;
    logic        ce;
    logic [16:0] stim;
    logic        chk;
    int          tests;
    int          fails;
    longint      exp_v [N];
    longint      act   [N];

    conv_round_if #(.IWID(8),  .OWID(4))  b0 ();
    conv_round_if #(.IWID(17), .OWID(17)) b1 ();
    conv_round_if #(.IWID(8),  .OWID(6))  b2 ();
    conv_round_if #(.IWID(5),  .OWID(4))  b3 ();
    conv_round_if #(.IWID(8),  .OWID(6))  b4 ();
    conv_round_if #(.IWID(12), .OWID(5))  b5 ();

    conv_round #(.IWID(8),  .OWID(4),  .SHIFT(0)) u0 (.i_clk(clk), .i_reset(rst), .bus(b0));
    conv_round #(.IWID(17), .OWID(17), .SHIFT(0)) u1 (.i_clk(clk), .i_reset(rst), .bus(b1));
    conv_round #(.IWID(8),  .OWID(6),  .SHIFT(2)) u2 (.i_clk(clk), .i_reset(rst), .bus(b2));
    conv_round #(.IWID(5),  .OWID(4),  .SHIFT(0)) u3 (.i_clk(clk), .i_reset(rst), .bus(b3));
    conv_round #(.IWID(8),  .OWID(6),  .SHIFT(4)) u4 (.i_clk(clk), .i_reset(rst), .bus(b4));
    conv_round #(.IWID(12), .OWID(5),  .SHIFT(3)) u5 (.i_clk(clk), .i_reset(rst), .bus(b5));

    assign b0.i_ce = ce;  assign b0.i_val = stim[7:0];
    assign b1.i_ce = ce;  assign b1.i_val = stim[16:0];
    assign b2.i_ce = ce;  assign b2.i_val = stim[7:0];
    assign b3.i_ce = ce;  assign b3.i_val = stim[4:0];
    assign b4.i_ce = ce;  assign b4.i_val = stim[7:0];
    assign b5.i_ce = ce;  assign b5.i_val = stim[11:0];

    always_comb begin
        act[0] = 64'($unsigned(b0.o_val));
        act[1] = 64'($unsigned(b1.o_val));
        act[2] = 64'($unsigned(b2.o_val));
        act[3] = 64'($unsigned(b3.o_val));
        act[4] = 64'($unsigned(b4.o_val));
        act[5] = 64'($unsigned(b5.o_val));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference model. It takes the signed value held in the
    // retained K bits and divides it by 2^D using floor division. It then
    // rounds the remainder against one half, sending ties to the even
    // quotient. The result is wrapped to OWID bits.
    function automatic longint model(input int iw, input int ow, input int sh, input longint raw);
        longint v, q, r, half;
        int     k, d;
        k = iw - sh;
        if (iw == ow) return raw & ((longint'(1) << iw) - 1);
        v = raw & ((longint'(1) << k) - 1);
        if (v[k-1]) v = v - (longint'(1) << k);
        if (k <= ow) begin
            q = v;
        end else begin
            d    = k - ow;
            q    = v >>> d;
            r    = v - (q <<< d);
            half = longint'(1) << (d - 1);
            if (r > half || (r == half && q[0])) q = q + 1;
        end
        return q & ((longint'(1) << ow) - 1);
    endfunction

    // Cycle-level expectation: the output takes the model's value of the
    // sample presented on each enabled edge, and reset clears it.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) exp_v[i] <= 0;
            else if (ce) exp_v[i] <= model(IW[i], OW[i], SH[i], 64'(stim));
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            for (int i = 0; i < N; i++) begin
                tests++;
                if (act[i] !== exp_v[i]) begin
                    fails++;
                    $display("FAIL stream cfg%0d t=%0t: got %h, expected %h", i, $time, act[i], exp_v[i]);
                end
            end
        end
    end

    task automatic check(input string name, input longint got, input longint want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic step(input logic [16:0] v, input logic c);
        stim = v;
        ce   = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk   = 1'b0;
        rst   = 1'b1;
        ce    = 1'b0;
        stim  = '0;

        // These expectations are worked out by hand and pin the reference model.
        check("model_pin_half", model(8, 4, 0, 64'h18), 64'h2);
        check("model_pin_neg",  model(8, 4, 0, 64'hE9), 64'hF);
        check("model_pin_d",    model(5, 4, 0, 64'h1F), 64'h0);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk = 1'b1;
        for (int i = 0; i < N; i++) check($sformatf("reset_cfg%0d", i), act[i], 0);
        rst = 1'b0;

        // Exact-half and off-half cases, and wrap-around, with cfg 8/4/0.
        step(17'b0001_1000, 1'b1); check("half_1p5",   act[0], 4'b0010);
        step(17'b0010_1000, 1'b1); check("half_2p5",   act[0], 4'b0010);
        step(17'b1111_1000, 1'b1); check("half_m0p5",  act[0], 4'b0000);
        step(17'b0001_1001, 1'b1); check("above_half", act[0], 4'b0010);
        step(17'b0001_0111, 1'b1); check("below_half", act[0], 4'b0001);
        step(17'b1110_0111, 1'b1); check("neg_below",  act[0], 4'b1110);
        step(17'b1110_1001, 1'b1); check("neg_above",  act[0], 4'b1111);
        step(17'b0111_1000, 1'b1); check("wrap",       act[0], 4'b1000);
        step(17'b0111_0111, 1'b1); check("no_wrap",    act[0], 4'b0111);

        // Pass-through, exact-fit, single-LSB, sign-extend and shifted-rounding modes.
        step(17'h1ABCD, 1'b1);      check("mode_a",    act[1], 17'h1ABCD);
        step(17'b1100_0101, 1'b1);  check("mode_c",    act[2], 6'b00_0101);
        step(17'b0_0011, 1'b1);     check("mode_d_3",  act[3], 4'b0010);
        step(17'b0_0001, 1'b1);     check("mode_d_1",  act[3], 4'b0000);
        step(17'b1_1111, 1'b1);     check("mode_d_m1", act[3], 4'b0000);
        step(17'b0000_1010, 1'b1);  check("mode_b",    act[4], 6'b11_1010);
        step(17'hE18, 1'b1);        check("mode_e_sh", act[5], 5'b00010);

        // Enable hold and reset.
        step(17'b0001_1000, 1'b1); check("load", act[0], 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step(17'($urandom), 1'b0);
            check($sformatf("hold%0d", i), act[0], 4'b0010);
        end
        rst = 1'b1;
        step(17'b0001_1000, 1'b1); check("reset_mid", act[0], 4'b0000);
        rst = 1'b0;
        step(17'b0010_1000, 1'b1); check("after_reset", act[0], 4'b0010);

        // Random stream with a toggling enable. The negedge compare process
        // checks every output on every cycle.
        for (int i = 0; i < 1000; i++) begin
            step(17'($urandom), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
